// File: rtl/multiplier_iter_if.sv
// Request/response bundle between M-extension decode and the iterative multiplier.
// Decode side drives the request; the multiplier returns busy/done/result.
interface multiplier_iter_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             kill_i;
  logic [WIDTH-1:0] op_A_i;
  logic [WIDTH-1:0] op_B_i;
  logic             signed_A_i;
  logic             signed_B_i;
  logic             upper_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i,
    output kill_i,
    output op_A_i,
    output op_B_i,
    output signed_A_i,
    output signed_B_i,
    output upper_i,
    input  busy_o,
    input  done_o,
    input  result_o
  );

  modport slave (
    input  start_i,
    input  kill_i,
    input  op_A_i,
    input  op_B_i,
    input  signed_A_i,
    input  signed_B_i,
    input  upper_i,
    output busy_o,
    output done_o,
    output result_o
  );
endinterface

// File: rtl/multiplier_iter.sv
// Iterative RV32M multiplier: BITS_PER_CYCLE multiplier bits per clock,
// full 2*WIDTH product, one-cycle replay of a repeated operand pair.
module multiplier_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4,
  parameter int PAIR_CACHE     = 1
) (
  input logic         clk_i,
  input logic         rst_i,
  multiplier_iter_if.slave bus
);
  localparam int K      = BITS_PER_CYCLE;
  localparam int CYCLES = WIDTH / K;
  localparam int PW     = 2 * WIDTH;
  localparam int CW     = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  if (!(K == 1 || K == 2 || K == 4 || K == 8) ||
      (WIDTH % K) != 0 || WIDTH < 2 ||
      !(PAIR_CACHE == 0 || PAIR_CACHE == 1)) begin : g_bad_param
    $error("multiplier_iter: illegal WIDTH/BITS_PER_CYCLE/PAIR_CACHE");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic             done_q;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             upper;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sgn_a;
  logic             sgn_b;
  logic [WIDTH-1:0] result;

  logic [PW-1:0]    c_prod;
  logic [WIDTH-1:0] c_a;
  logic [WIDTH-1:0] c_b;
  logic             c_sa;
  logic             c_sb;
  logic             c_valid;

  logic          open;
  logic          accept;
  logic          hit;
  logic          last;
  logic [K-1:0]  dig;
  logic [K:0]    dext;
  logic [PW-1:0] dwide;
  logic [PW-1:0] term;
  logic [PW-1:0] full;

  assign open   = (state == IDLE) || (state == DONE);
  assign accept = open && bus.start_i && !bus.kill_i;

  // upper_i is deliberately left out: MULH followed by MUL replays
  assign hit = (PAIR_CACHE != 0) && c_valid &&
               (bus.op_A_i == c_a) && (bus.op_B_i == c_b) &&
               (bus.signed_A_i == c_sa) && (bus.signed_B_i == c_sb);

  assign last = (cnt == LAST);

  // The top digit of a signed multiplier carries negative weight
  assign dig   = b_sh[K-1:0];
  assign dext  = {last & sgn_b & dig[K-1], dig};
  assign dwide = {{(PW-K-1){dext[K]}}, dext};
  assign term  = a_sh * dwide;
  assign full  = acc + term;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start_i) state_nx = hit ? DONE : CALC;
        else             state_nx = IDLE;
      end
      CALC: begin
        if (last) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.kill_i) state_nx = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state_nx == DONE);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      upper   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      sgn_a   <= 1'b0;
      sgn_b   <= 1'b0;
      result  <= '0;
      c_prod  <= '0;
      c_a     <= '0;
      c_b     <= '0;
      c_sa    <= 1'b0;
      c_sb    <= 1'b0;
      c_valid <= 1'b0;
    end else if (bus.kill_i) begin
      c_valid <= 1'b0;
    end else if (accept) begin
      op_a  <= bus.op_A_i;
      op_b  <= bus.op_B_i;
      sgn_a <= bus.signed_A_i;
      sgn_b <= bus.signed_B_i;
      upper <= bus.upper_i;
      acc   <= '0;
      cnt   <= '0;
      b_sh  <= bus.op_B_i;
      a_sh  <= {{WIDTH{bus.signed_A_i & bus.op_A_i[WIDTH-1]}},
                bus.op_A_i};
      if (hit) begin
        result <= bus.upper_i ? c_prod[PW-1:WIDTH]
                              : c_prod[WIDTH-1:0];
      end
    end else if (state == CALC) begin
      acc  <= full;
      a_sh <= a_sh << K;
      b_sh <= b_sh >> K;
      cnt  <= cnt + CW'(1);
      if (last) begin
        result  <= upper ? full[PW-1:WIDTH] : full[WIDTH-1:0];
        c_prod  <= full;
        c_a     <= op_a;
        c_b     <= op_b;
        c_sa    <= sgn_a;
        c_sb    <= sgn_b;
        c_valid <= 1'b1;
      end
    end
  end

  assign bus.busy_o   = (state == CALC);
  assign bus.done_o   = done_q;
  assign bus.result_o = result;
endmodule
